// File: rtl/gpio_intr_ctrl_if.sv
// Signal bundle between a GPIO interrupt controller and its host/pad side.
// The master drives pads and configuration; the slave returns data, status and irq.
interface gpio_intr_ctrl_if #(
   parameter int WIDTH    = 32,
   parameter int DB_CNT_W = 8
);
   logic [WIDTH-1:0]    pad_gpio_in;
   logic [WIDTH-1:0]    cfg_posedge_int_sel;
   logic [WIDTH-1:0]    cfg_negedge_int_sel;
   logic [WIDTH-1:0]    cfg_level_high_sel;
   logic [WIDTH-1:0]    cfg_level_low_sel;
   logic [WIDTH-1:0]    cfg_int_mask;
   logic [WIDTH-1:0]    cfg_db_en;
   logic [DB_CNT_W-1:0] cfg_db_cnt;
   logic [WIDTH-1:0]    cfg_int_clr;
   logic [WIDTH-1:0]    gpio_data_in;
   logic [WIDTH-1:0]    gpio_int_status;
   logic                gpio_irq;

   modport master (
      output pad_gpio_in, cfg_posedge_int_sel, cfg_negedge_int_sel,
             cfg_level_high_sel, cfg_level_low_sel, cfg_int_mask,
             cfg_db_en, cfg_db_cnt, cfg_int_clr,
      input  gpio_data_in, gpio_int_status, gpio_irq
   );

   modport slave (
      input  pad_gpio_in, cfg_posedge_int_sel, cfg_negedge_int_sel,
             cfg_level_high_sel, cfg_level_low_sel, cfg_int_mask,
             cfg_db_en, cfg_db_cnt, cfg_int_clr,
      output gpio_data_in, gpio_int_status, gpio_irq
   );
endinterface

// File: rtl/gpio_intr_ctrl.sv
// GPIO input synchroniser, optional per-bit debounce, edge/level interrupt status and irq.
// Define GPIO_DEBOUNCE_EN to build the debounce counters; otherwise cfg_db_en/cfg_db_cnt are ignored.
module gpio_intr_ctrl #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT_W    = 8
) (
   input logic             mclk,
   input logic             h_reset,
   gpio_intr_ctrl_if.slave gpio
);

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_status;
   logic             r_irq;
   logic [WIDTH-1:0] w_ev;

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= gpio.pad_gpio_in;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam logic [DB_CNT_W-1:0] CntOne = {{(DB_CNT_W-1){1'b0}}, 1'b1};
   logic [DB_CNT_W-1:0] r_cnt [WIDTH];

   // A debounced bit only follows sync after it has disagreed for cfg_db_cnt+1 cycles;
   // the counter parks at all-ones so a lowered threshold cannot fire until it clears.
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         r_stable <= '0;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!gpio.cfg_db_en[i]) begin
               r_stable[i] <= w_sync[i];
               r_cnt[i]    <= '0;
            end else if (w_sync[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == gpio.cfg_db_cnt) begin
               r_stable[i] <= w_sync[i];
               r_cnt[i]    <= '0;
            end else if (r_cnt[i] != '1) begin
               r_cnt[i] <= r_cnt[i] + CntOne;
            end
         end
      end
   end
`else
   logic w_unused_db;
   assign w_unused_db = ^{gpio.cfg_db_en, gpio.cfg_db_cnt};

   always_ff @(posedge mclk) begin
      if (h_reset) r_stable <= '0;
      else         r_stable <= w_sync;
   end
`endif

   assign w_ev = (gpio.cfg_posedge_int_sel & ~r_prev &  r_stable)
               | (gpio.cfg_negedge_int_sel &  r_prev & ~r_stable)
               | (gpio.cfg_level_high_sel  &  r_stable)
               | (gpio.cfg_level_low_sel   & ~r_stable);

   // Status is sticky with W1C; a fresh event on the same bit beats the clear.
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         r_prev   <= '0;
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_prev   <= r_stable;
         r_status <= (r_status & ~gpio.cfg_int_clr) | w_ev;
         r_irq    <= |(r_status & gpio.cfg_int_mask);
      end
   end

   assign gpio.gpio_data_in    = r_stable;
   assign gpio.gpio_int_status = r_status;
   assign gpio.gpio_irq        = r_irq;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// Self-checking bench for gpio_intr_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model. Honours GPIO_DEBOUNCE_EN like the design.
module tb_gpio_intr_ctrl;

   localparam int W  = 32;
   localparam int SS = 2;
   localparam int DW = 8;

   logic mclk = 1'b0;
   logic h_reset;
   int   testsRun = 0;
   int   testsFailed = 0;

   always #5 mclk = ~mclk;

   gpio_intr_ctrl_if #(.WIDTH(W), .DB_CNT_W(DW)) bus ();

   gpio_intr_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CNT_W(DW)) dut (
      .mclk    (mclk),
      .h_reset (h_reset),
      .gpio    (bus)
   );

   // Behavioural model: pads appear at the sync output SS edges after sampling,
   // then each bit settles (immediately or after a qualified disagreement run).
   logic [SS-1:0][W-1:0] mHist = '0;
   logic [W-1:0] mStable = '0;
   logic [W-1:0] mPrev = '0;
   logic [W-1:0] mStatus = '0;
   logic         mIrq = 1'b0;
   int           mCnt [W];

   initial for (int i = 0; i < W; i++) mCnt[i] = 0;

   always @(posedge mclk) begin
      automatic logic [W-1:0] syncNow = mHist[SS-1];
      automatic logic [W-1:0] nStable = mStable;
      automatic logic [W-1:0] ev = '0;
      automatic int           nCnt [W];
      automatic int           maxCnt = (1 << DW) - 1;
      automatic logic         dbOn;
      if (h_reset) begin
         mHist   <= '0;
         mStable <= '0;
         mPrev   <= '0;
         mStatus <= '0;
         mIrq    <= 1'b0;
         for (int i = 0; i < W; i++) mCnt[i] <= 0;
      end else begin
         for (int i = 0; i < W; i++) begin
`ifdef GPIO_DEBOUNCE_EN
            dbOn = bus.cfg_db_en[i];
`else
            dbOn = 1'b0;
`endif
            nCnt[i] = 0;
            if (!dbOn) nStable[i] = syncNow[i];
            else if (syncNow[i] != mStable[i]) begin
               if (mCnt[i] == int'(bus.cfg_db_cnt)) nStable[i] = syncNow[i];
               else nCnt[i] = (mCnt[i] < maxCnt) ? mCnt[i] + 1 : maxCnt;
            end
            if (bus.cfg_posedge_int_sel[i] && !mPrev[i] &&  mStable[i]) ev[i] = 1'b1;
            if (bus.cfg_negedge_int_sel[i] &&  mPrev[i] && !mStable[i]) ev[i] = 1'b1;
            if (bus.cfg_level_high_sel[i] &&  mStable[i]) ev[i] = 1'b1;
            if (bus.cfg_level_low_sel[i]  && !mStable[i]) ev[i] = 1'b1;
         end
         mStatus <= (mStatus & ~bus.cfg_int_clr) | ev;
         mIrq    <= ((mStatus & bus.cfg_int_mask) != '0);
         mPrev   <= mStable;
         mStable <= nStable;
         mCnt    <= nCnt;
         mHist   <= {mHist[SS-2:0], bus.pad_gpio_in};
      end
   end

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic clearCfg();
      bus.cfg_posedge_int_sel = '0;
      bus.cfg_negedge_int_sel = '0;
      bus.cfg_level_high_sel  = '0;
      bus.cfg_level_low_sel   = '0;
      bus.cfg_int_mask        = '0;
      bus.cfg_db_en           = '0;
      bus.cfg_db_cnt          = '0;
      bus.cfg_int_clr         = '0;
   endtask

   task automatic clearStatus();
      bus.cfg_int_clr = '1;
      tick();
      bus.cfg_int_clr = '0;
   endtask

   task automatic test_reset();
      clearCfg();
      bus.pad_gpio_in = $urandom;
      h_reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         testsRun++;
         if (bus.gpio_data_in !== '0 || bus.gpio_int_status !== '0 || bus.gpio_irq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: data=%h status=%h irq=%b, required all 0",
                     bus.gpio_data_in, bus.gpio_int_status, bus.gpio_irq);
         end
      end
      bus.pad_gpio_in = '0;
      h_reset = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_posedge_latency();
      clearCfg();
      bus.cfg_posedge_int_sel[3] = 1'b1;
      bus.cfg_int_mask[3] = 1'b1;
      tick();
      bus.pad_gpio_in[3] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         testsRun++;
         if (bus.gpio_data_in[3] !== (k >= 3)) begin
            testsFailed++;
            $display("[TB] FAIL posedge_data k=%0d: got %b, required %b", k, bus.gpio_data_in[3], k >= 3);
         end
         testsRun++;
         if (bus.gpio_int_status[3] !== (k >= 4)) begin
            testsFailed++;
            $display("[TB] FAIL posedge_status k=%0d: got %b, required %b", k, bus.gpio_int_status[3], k >= 4);
         end
         testsRun++;
         if (bus.gpio_irq !== (k >= 5)) begin
            testsFailed++;
            $display("[TB] FAIL posedge_irq k=%0d: got %b, required %b", k, bus.gpio_irq, k >= 5);
         end
      end
   endtask

   task automatic test_set_wins();
      clearCfg();
      bus.cfg_negedge_int_sel[0] = 1'b1;
      bus.pad_gpio_in[0] = 1'b1;
      repeat (5) tick();
      clearStatus();
      tick();
      bus.pad_gpio_in[0] = 1'b0;
      repeat (3) tick();
      testsRun++;
      if (bus.gpio_int_status[0] !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL negedge_before: got %b, required 0", bus.gpio_int_status[0]);
      end
      bus.cfg_int_clr[0] = 1'b1;
      tick();
      bus.cfg_int_clr[0] = 1'b0;
      testsRun++;
      if (bus.gpio_int_status[0] !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL set_wins: got %b, required 1", bus.gpio_int_status[0]);
      end
      tick();
      testsRun++;
      if (bus.gpio_int_status[0] !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL status_sticky: got %b, required 1", bus.gpio_int_status[0]);
      end
      bus.cfg_int_clr[0] = 1'b1;
      tick();
      bus.cfg_int_clr[0] = 1'b0;
      testsRun++;
      if (bus.gpio_int_status[0] !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL later_clear: got %b, required 0", bus.gpio_int_status[0]);
      end
   endtask

   task automatic test_level_mask();
      automatic logic [W-1:0] want;
      clearCfg();
      bus.cfg_level_high_sel[7] = 1'b1;
      bus.pad_gpio_in = '0;
      bus.pad_gpio_in[7] = 1'b1;
      bus.cfg_int_clr = '1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         want = (k >= 4) ? (W'(1) << 7) : '0;
         testsRun++;
         if (bus.gpio_int_status !== want || bus.gpio_irq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL level_clear k=%0d: status=%h irq=%b, required status=%h irq=0",
                     k, bus.gpio_int_status, bus.gpio_irq, want);
         end
      end
      bus.cfg_int_clr = '0;
      bus.cfg_int_mask[7] = 1'b1;
      tick();
      testsRun++;
      if (bus.gpio_irq !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL unmask_irq: got %b, required 1", bus.gpio_irq);
      end
      bus.cfg_int_mask[7] = 1'b0;
      tick();
      testsRun++;
      if (bus.gpio_irq !== 1'b0 || bus.gpio_int_status[7] !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL remask: irq=%b status7=%b, required irq=0 status7=1",
                  bus.gpio_irq, bus.gpio_int_status[7]);
      end
      bus.cfg_level_high_sel = '0;
      bus.pad_gpio_in = '0;
      repeat (5) tick();
      clearStatus();
   endtask

`ifdef GPIO_DEBOUNCE_EN
   task automatic test_debounce();
      clearCfg();
      bus.cfg_posedge_int_sel[5] = 1'b1;
      bus.cfg_db_en[5] = 1'b1;
      bus.cfg_db_cnt = 8'd4;
      repeat (3) tick();
      clearStatus();
      bus.pad_gpio_in[5] = 1'b1;
      repeat (3) tick();
      bus.pad_gpio_in[5] = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         testsRun++;
         if (bus.gpio_data_in[5] !== 1'b0 || bus.gpio_int_status[5] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL glitch_reject k=%0d: data5=%b status5=%b, required 0/0",
                     k, bus.gpio_data_in[5], bus.gpio_int_status[5]);
         end
      end
      bus.pad_gpio_in[5] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         testsRun++;
         if (bus.gpio_data_in[5] !== (k >= 7) || bus.gpio_int_status[5] !== (k >= 8)) begin
            testsFailed++;
            $display("[TB] FAIL debounce_pass k=%0d: data5=%b status5=%b, required %b/%b",
                     k, bus.gpio_data_in[5], bus.gpio_int_status[5], k >= 7, k >= 8);
         end
      end
      bus.pad_gpio_in[5] = 1'b0;
   endtask
`else
   task automatic test_no_debounce_build();
      clearCfg();
      bus.cfg_db_en = '1;
      bus.cfg_db_cnt = 8'd255;
      bus.cfg_posedge_int_sel[9] = 1'b1;
      bus.cfg_int_mask[9] = 1'b1;
      repeat (3) tick();
      clearStatus();
      bus.pad_gpio_in[9] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         testsRun++;
         if (bus.gpio_data_in[9] !== (k >= 3) || bus.gpio_int_status[9] !== (k >= 4) ||
             bus.gpio_irq !== (k >= 5)) begin
            testsFailed++;
            $display("[TB] FAIL db_ignored k=%0d: data=%b status=%b irq=%b, required %b/%b/%b",
                     k, bus.gpio_data_in[9], bus.gpio_int_status[9], bus.gpio_irq,
                     k >= 3, k >= 4, k >= 5);
         end
      end
   endtask
`endif

   task automatic test_reset_midflight();
      clearCfg();
      bus.pad_gpio_in = '0;
      repeat (5) tick();
      clearStatus();
      bus.cfg_int_mask = '1;
      bus.cfg_level_high_sel[20] = 1'b1;
      bus.cfg_posedge_int_sel[12] = 1'b1;
      bus.cfg_posedge_int_sel[5] = 1'b1;
      bus.cfg_db_en[5] = 1'b1;
      bus.cfg_db_cnt = 8'd50;
      bus.pad_gpio_in[20] = 1'b1;
      bus.pad_gpio_in[12] = 1'b1;
      bus.pad_gpio_in[5] = 1'b1;
      repeat (6) tick();
      testsRun++;
      if (bus.gpio_irq !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL pre_reset_irq: got %b, required 1", bus.gpio_irq);
      end
      h_reset = 1'b1;
      bus.cfg_level_high_sel = '0;
      tick();
      h_reset = 1'b0;
      testsRun++;
      if (bus.gpio_data_in !== '0 || bus.gpio_int_status !== '0 || bus.gpio_irq !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midflight_reset: data=%h status=%h irq=%b, required all 0",
                  bus.gpio_data_in, bus.gpio_int_status, bus.gpio_irq);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         testsRun++;
         if (bus.gpio_int_status[12] !== (k >= 4)) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_edge k=%0d: got %b, required %b",
                     k, bus.gpio_int_status[12], k >= 4);
         end
      end
      clearStatus();
      for (int k = 1; k <= 4; k++) begin
         tick();
         testsRun++;
         if (bus.gpio_int_status[12] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_edge k=%0d: got %b, required 0", k, bus.gpio_int_status[12]);
         end
      end
   endtask

   task automatic test_random();
      clearCfg();
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 0) begin
            bus.cfg_posedge_int_sel = $urandom & $urandom;
            bus.cfg_negedge_int_sel = $urandom & $urandom;
            bus.cfg_level_high_sel  = $urandom & $urandom & $urandom;
            bus.cfg_level_low_sel   = $urandom & $urandom & $urandom;
            bus.cfg_int_mask        = $urandom;
            bus.cfg_db_en           = $urandom;
         end
         if (c % 17 == 0) bus.cfg_db_cnt = DW'($urandom_range(0, 6));
         bus.pad_gpio_in ^= ($urandom & $urandom & $urandom & $urandom);
         bus.cfg_int_clr = $urandom & $urandom & $urandom;
         h_reset = ($urandom_range(0, 249) == 0);
         tick();
         testsRun++;
         if (bus.gpio_data_in !== mStable) begin
            testsFailed++;
            $display("[TB] FAIL rand_data c=%0d: got %h, required %h", c, bus.gpio_data_in, mStable);
         end
         testsRun++;
         if (bus.gpio_int_status !== mStatus) begin
            testsFailed++;
            $display("[TB] FAIL rand_status c=%0d: got %h, required %h", c, bus.gpio_int_status, mStatus);
         end
         testsRun++;
         if (bus.gpio_irq !== mIrq) begin
            testsFailed++;
            $display("[TB] FAIL rand_irq c=%0d: got %b, required %b", c, bus.gpio_irq, mIrq);
         end
      end
      h_reset = 1'b0;
   endtask

   initial begin
      h_reset = 1'b1;
      clearCfg();
      bus.pad_gpio_in = '0;
      test_reset();
      test_posedge_latency();
      test_set_wins();
      test_level_mask();
`ifdef GPIO_DEBOUNCE_EN
      test_debounce();
`else
      test_no_debounce_build();
`endif
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
